// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, functs, FSM states, ALU ops and cause codes for the multicycle core
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_BREAK = 6'h0D;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_OVF  = 2'd1;
   localparam logic [1:0] CAUSE_ILL  = 2'd2;

   typedef enum logic [3:0] {
      RST, FETCH, DECODE, EXEC_R, EXEC_I, MEMADDR, MEMRD,
      MEMWR, WB, BRANCH, JUMP, EXC, HALT
   } state_t;

   typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

   // Returns {signed_overflow, result}; overflow is only meaningful for ADD/SUB.
   function automatic logic [32:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      logic        v;
      r = 32'd0;
      v = 1'b0;
      case (op)
         ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         AND: r = a & b;
         OR:  r = a | b;
         SLT: r = {31'd0, $signed(a) < $signed(b)};
         default: r = 32'd0;
      endcase
      return {v, r};
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async read ports, one sync write port, $0 hardwired
module mips_regfile (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_raddr1,
   input  logic [4:0]  i_raddr2,
   output logic [31:0] o_rdata1,
   output logic [31:0] o_rdata2,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata
);

   logic [31:0] r_regs [0:31];

   assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

endmodule

// File: rtl/mips_multiciclo_hs.sv
// rtl/mips_multiciclo_hs.sv - multicycle MIPS-subset core with handshaked shared memory port,
// exceptions (overflow/illegal) with EPC/cause capture and a halt state
module mips_multiciclo_hs
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        halted,
   output logic [3:0]  state
);

   state_t      r_state;
   logic [31:0] r_pc, r_epc, r_ir, r_a, r_b, r_aluout, r_mdr;
   logic [1:0]  r_cause, r_exc_code;

   logic [5:0]  w_op, w_funct;
   logic [31:0] w_simm, w_rdata1, w_rdata2, w_alu_b, w_alu_res, w_wdata;
   logic [4:0]  w_waddr;
   logic        w_alu_ovf, w_funct_ok;
   alu_op_t     w_alu_op;

   assign w_op    = r_ir[31:26];
   assign w_funct = r_ir[5:0];
   assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_waddr = (w_op == OP_RTYPE) ? r_ir[15:11] : r_ir[20:16];
   assign w_wdata = (w_op == OP_LW) ? r_mdr : r_aluout;

   mips_regfile u_rf (
      .i_clk    (clock),
      .i_rst_n  (reset),
      .i_raddr1 (r_ir[25:21]),
      .i_raddr2 (r_ir[20:16]),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2),
      .i_we     (r_state == WB),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wdata)
   );

   always_comb begin
      w_alu_op   = ADD;
      w_funct_ok = 1'b1;
      if (r_state == EXEC_R) begin
         case (w_funct)
            FN_ADD:  w_alu_op = ADD;
            FN_SUB:  w_alu_op = SUB;
            FN_AND:  w_alu_op = AND;
            FN_OR:   w_alu_op = OR;
            FN_SLT:  w_alu_op = SLT;
            default: w_funct_ok = 1'b0;
         endcase
      end
   end

   assign w_alu_b = (r_state == EXEC_R) ? r_b : w_simm;
   assign {w_alu_ovf, w_alu_res} = alu_eval(w_alu_op, r_a, w_alu_b);

   // Bus signals come straight from registered state so they hold steady across wait states.
   assign mem_req   = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
   assign mem_we    = (r_state == MEMWR);
   assign mem_addr  = (r_state == FETCH) ? r_pc : r_aluout;
   assign mem_wdata = r_b;
   assign pc        = r_pc;
   assign epc       = r_epc;
   assign cause     = r_cause;
   assign halted    = (r_state == HALT);
   assign state     = r_state;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= RST;
         r_pc       <= RESET_PC;
         r_epc      <= 32'd0;
         r_cause    <= CAUSE_NONE;
         r_exc_code <= CAUSE_NONE;
         r_ir       <= 32'd0;
         r_a        <= 32'd0;
         r_b        <= 32'd0;
         r_aluout   <= 32'd0;
         r_mdr      <= 32'd0;
      end else begin
         case (r_state)
            RST: r_state <= FETCH;
            FETCH: if (mem_ready) begin
               r_ir    <= mem_rdata;
               r_pc    <= r_pc + 32'd4;
               r_state <= DECODE;
            end
            DECODE: begin
               r_a      <= w_rdata1;
               r_b      <= w_rdata2;
               r_aluout <= r_pc + (w_simm << 2);
               case (w_op)
                  OP_RTYPE:       r_state <= EXEC_R;
                  OP_ADDI:        r_state <= EXEC_I;
                  OP_LW, OP_SW:   r_state <= MEMADDR;
                  OP_BEQ, OP_BNE: r_state <= BRANCH;
                  OP_J:           r_state <= JUMP;
                  default: begin r_exc_code <= CAUSE_ILL; r_state <= EXC; end
               endcase
            end
            EXEC_R: begin
               if (w_funct == FN_BREAK)  r_state <= HALT;
               else if (!w_funct_ok) begin r_exc_code <= CAUSE_ILL; r_state <= EXC; end
               else if (w_alu_ovf)   begin r_exc_code <= CAUSE_OVF; r_state <= EXC; end
               else begin r_aluout <= w_alu_res; r_state <= WB; end
            end
            EXEC_I: begin
               if (w_alu_ovf) begin r_exc_code <= CAUSE_OVF; r_state <= EXC; end
               else begin r_aluout <= w_alu_res; r_state <= WB; end
            end
            MEMADDR: begin
               r_aluout <= w_alu_res;
               r_state  <= (w_op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: if (mem_ready) begin r_mdr <= mem_rdata; r_state <= WB; end
            MEMWR: if (mem_ready) r_state <= FETCH;
            WB:    r_state <= FETCH;
            BRANCH: begin
               if ((w_op == OP_BEQ) == (r_a == r_b)) r_pc <= r_aluout;
               r_state <= FETCH;
            end
            JUMP: begin
               r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
               r_state <= FETCH;
            end
            EXC: begin
               r_epc   <= r_pc - 32'd4;
               r_cause <= r_exc_code;
               r_pc    <= EXC_VECTOR;
               r_state <= FETCH;
            end
            HALT:    r_state <= HALT;
            default: r_state <= RST;
         endcase
      end
   end

endmodule

// File: doc/mips_multiciclo_hs.md
# mips_multiciclo_hs

Multicycle MIPS-subset core, next generation of the team's processor top: one controller FSM, single shared instruction/data memory port, internal register file. Adds a variable-latency memory handshake, branches/jumps, overflow and illegal-opcode exceptions with EPC/cause capture, and a halt state. It sits at the top of the design and connects directly to the memory wrapper.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080: PC loaded on any exception.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  32  byte address, word aligned; PC in fetch, ALUOut in data access.
- mem_wdata  out  32  store data (register B).
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  transaction completes on the edge where mem_req & mem_ready.
- pc  out  32  current PC.
- epc  out  32  address of the faulting instruction.
- cause  out  2  0 none, 1 overflow, 2 illegal opcode/funct.
- halted  out  1  high in HALT.
- state  out  4  FSM state encoding, for debug.

## Operation
- Instructions: R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, break 0x0D; addi 0x08; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02. All other opcodes/functs are illegal.
- Registers: 32 × 32. $0 reads zero; writes to $0 are ignored. Immediates are sign-extended.
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, MEMADDR, MEMRD, MEMWR, WB, BRANCH, JUMP, EXC, HALT.
- RST: entered while reset=0. Next cycle goes to FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Stays until mem_ready. On completion: IR<=mem_rdata, pc<=pc+4.
- DECODE: A<=rs, B<=rt, ALUOut<=pc+(simm<<2). Dispatches by opcode; illegal opcode goes to EXC with cause=2.
- EXEC_R: computes result, then WB (rd). Illegal funct goes to EXC with cause 2. break goes to HALT. add/sub signed overflow goes to EXC with cause 1, with no register write.
- EXEC_I: addi result, then WB (rt). Overflow is handled as in EXEC_R.
- MEMADDR: ALUOut<=A+simm. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: mem_req=1, mem_we=0. On ready, MDR<=mem_rdata, then WB (rt <= MDR).
- MEMWR: mem_req=1, mem_we=1, mem_wdata=B. On ready, goes to FETCH.
- WB: writes one register, then goes to FETCH.
- BRANCH: if the condition holds (beq: A==B; bne: A!=B), pc<=ALUOut. Then goes to FETCH.
- JUMP: pc<={pc[31:28], IR[25:0], 2'b00}. Then goes to FETCH.
- EXC: epc<=pc-4, cause latched, pc<=EXC_VECTOR. Then goes to FETCH.
- HALT: absorbing; only reset leaves it.
- slt is a signed compare; the result is 32'd1 or 32'd0.

## Timing
- Reset values (the cycle after an edge with reset=0): pc=RESET_PC, epc=0, cause=0, IR/A/B/ALUOut/MDR=0, all registers 0, state=RST, mem_req=0, mem_we=0, halted=0.
- mem_req/mem_we/mem_addr/mem_wdata are decoded from registered state. They stay stable from assertion until the completing edge.
- Cycles per instruction with zero-wait memory (ready in the first request cycle):
  - R/addi: 4
  - lw: 5
  - sw: 4
  - beq/bne/j: 3
  - exception: 4 (FETCH, DECODE, EXEC, EXC)
- Each cycle with mem_req=1 and mem_ready=0 adds exactly one cycle.
- mem_ready while mem_req=0 is ignored.
- reset=0 during a pending transaction: mem_req drops at the next edge, and no register or memory side effect follows.
- Writes become visible to a read in the following instruction; there is no intra-instruction forwarding.

## Structure
- Package mips_pkg holds:
  - opcode and funct localparams;
  - state_t enum (4-bit);
  - alu_op_t enum {ADD, SUB, AND, OR, SLT};
  - cause codes.
- One sub-module, mips_regfile: 2 read ports (combinational), 1 write port (synchronous), $0 hardwired, synchronous active-low clear.
- FSM, ALU and muxes are inline in the top.

## Test plan
- Reset release, memory always ready: first mem_addr=0, mem_req on the 2nd cycle after release. Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 → $3=12 after 12 cycles.
- Wait states: mem_ready asserted on the 3rd request cycle of every transaction → lw $4,0($0) of word 0xDEADBEEF gives $4=0xDEADBEEF, instruction takes 9 cycles, addr/we stable throughout.
- sw $3,16($0) then lw $5,16($0) → one write at 0x10 with data 12; $5=12.
- beq taken: $1==$1 with offset 2 from 0x20 → next fetch 0x2C. bne not taken → next fetch 0x24. j 0x40 → next fetch 0x100 (target field 0x40, shifted left by 2).
- add 0x7FFFFFFF+1 at 0x30 → rd unchanged, epc=0x30, cause=1, next fetch EXC_VECTOR. Opcode 0x3F → cause=2.
- break → halted=1, no further mem_req. reset=0 held mid-MEMRD with ready low → mem_req=0 next cycle, pc=RESET_PC, target register unchanged.
